regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised successor to the CPU's 8-bit register file: NREGS general registers of DATA_W bits, with an integrated single-cycle operation unit (move, increment/decrement, add-immediate, literal shift-in, bit set/clear/flip, register-pair funnel shifts, zero test). It adds a load scoreboard: loads are issued to the memory stage, complete out of order, and any dependent operation stalls through an `op_ready` handshake. It sits between the decoder (op side) and data memory (load/store side).

## Interface
- `DATA_W`, 8, register width in bits (≥ 4, power of two)
- `NREGS`, 16, number of registers (≥ 2); register 0 reads as 0 and ignores writes
- `AW`, $clog2(NREGS), register index width
- `IMM_W`, 4, immediate width; must be ≥ $clog2(DATA_W)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `op_valid`  in  1  operation present
- `op`  in  4  opcode: 0 NOP, 1 MOV, 2 INC, 3 DEC, 4 ADDI, 5 LIT, 6 SETB, 7 CLRB, 8 FLIPB, 9 SHLP, 10 SHRP, 11 LOAD, 12 STORE, 13 TSTZ; 14–15 behave as NOP
- `src`, `dst`  in  AW  source / destination index
- `imm`  in  IMM_W  immediate / bit index / shift amount
- `op_ready`  out  1  combinational; operation accepted on an edge where `op_valid && op_ready`
- `ld_req`  out  1  load issue pulse
- `ld_req_dst`  out  AW  destination tag of issued load
- `ld_valid`  in  1  load return
- `ld_dst`  in  AW  return tag
- `ld_data`  in  DATA_W  return data
- `st_valid`  out  1  store pulse
- `st_data`  out  DATA_W  value of R[src] at accept
- `zero_flag`  out  1  result of last TSTZ
- `err`  out  1  sticky: load return to a non-pending register

## Operation
- MOV: R[dst]=R[src]. INC/DEC: R[dst]=R[src]±1, modulo 2^DATA_W. ADDI: R[dst]=R[src]+zero-extended imm, modulo 2^DATA_W.
- LIT: R[dst]={R[dst][DATA_W-IMM_W-1:0], imm} (literal shift-in, IMM_W bits).
- SETB/CLRB/FLIPB: bit k=imm[$clog2(DATA_W)-1:0] of R[dst] set/cleared/inverted; other bits unchanged.
- SHLP, amount s=k: s=0 → R[dst]=R[src]; else R[dst]={R[dst][DATA_W-1-s:0], R[src][DATA_W-1:DATA_W-s]}.
- SHRP: s=0 → R[dst]=R[src]; else R[dst]={R[src][s-1:0], R[dst][DATA_W-1:s]}.
- LOAD: sets pending[dst], pulses `ld_req` with `ld_req_dst`=dst. STORE: pulses `st_valid` with R[src]. TSTZ: `zero_flag`=(R[src]==0).
- Scoreboard: `pending[NREGS]`, bit 0 always 0. `op_ready`=0 when `op_valid` and the op reads a pending src (MOV/INC/DEC/ADDI/SHLP/SHRP/STORE/TSTZ) or reads/writes a pending dst (every write op and LOAD). Otherwise `op_ready`=1, including when `op_valid`=0.
- Load return: when `ld_valid` and pending[ld_dst], R[ld_dst]=ld_data and pending cleared. When not pending, the data is dropped and `err` is set until reset.
- Load return and op write in the same cycle always target different registers (the scoreboard guarantees it); both commit.
- Writes to register 0 are discarded. LOAD to register 0 issues `ld_req` but sets no pending bit; its return is dropped without setting `err`.

## Timing
- Reset (async assert, sync-release usage): all registers 0, pending 0, `ld_req`/`st_valid`/`zero_flag`/`err` 0, `ld_req_dst` 0, `st_data` 0.
- Op result is written at the accept edge and visible to an op the very next cycle (latency 1, no bypass needed).
- `ld_req`, `st_valid`, `st_data`, `zero_flag` are registered: they update on the accept edge and pulse outputs are high for exactly one cycle.
- Pending is set at the LOAD accept edge, so a dependent op presented in the next cycle sees `op_ready`=0.
- Pending clears at the `ld_valid` edge. The stall decision uses registered pending (no return bypass), so a dependent op stalled during the return cycle is accepted the cycle after.
- Stalled ops have no side effects; the decoder holds the op stable while `op_ready`=0.
- Reset mid-stall or with loads outstanding drops all pending state; late returns after reset set `err`.

## Test plan
- Reset → all regs read 0 via STORE; MOV r3←r0, INC r3 twice, STORE r3 → `st_data`=2, one-cycle `st_valid`.
- DEC r5 from 0 → 0xFF; ADDI r5 imm 3 → 0x02 (wrap); TSTZ r5 → `zero_flag`=0; TSTZ r0 → `zero_flag`=1.
- LIT r4 imm 0xA then imm 0x5 → 0xA5; FLIPB r4 imm 0 → 0xA4; SETB imm 3 → 0xAC; CLRB imm 7 → 0x2C.
- r1=0x12, r2=0x34: SHLP r2←r1 s=4 → 0x41; SHRP r2←r1 s=4 → 0x24; s=0 → 0x12.
- LOAD r6, then MOV r7←r6 held: `op_ready`=0 until the cycle after `ld_valid` (ld_dst=6, 0x5A); then r7=0x5A. An independent INC r8 during the stall window is accepted.
- `ld_valid` with ld_dst=9 (not pending) → r9 unchanged, `err`=1 and stays high; assert `rst_n` low → `err`=0 immediately (asynchronous).

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised general register file with an integrated
// single-cycle operation unit and a load scoreboard. Loads are issued to
// the memory stage, return out of order, and any operation that depends
// on a register still waiting for its load is held off via o_op_ready.
module regfile_sb #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS),
  parameter int IMM_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_op_valid,
  input  logic [3:0]        i_op,
  input  logic [AW-1:0]     i_src,
  input  logic [AW-1:0]     i_dst,
  input  logic [IMM_W-1:0]  i_imm,
  output logic              o_op_ready,
  output logic              o_ld_req,
  output logic [AW-1:0]     o_ld_req_dst,
  input  logic              i_ld_valid,
  input  logic [AW-1:0]     i_ld_dst,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_st_valid,
  output logic [DATA_W-1:0] o_st_data,
  output logic              o_zero_flag,
  output logic              o_err
);

  localparam int KW = $clog2(DATA_W);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_INC   = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_LIT   = 4'd5;
  localparam logic [3:0] OP_SETB  = 4'd6;
  localparam logic [3:0] OP_CLRB  = 4'd7;
  localparam logic [3:0] OP_FLIPB = 4'd8;
  localparam logic [3:0] OP_SHLP  = 4'd9;
  localparam logic [3:0] OP_SHRP  = 4'd10;
  localparam logic [3:0] OP_LOAD  = 4'd11;
  localparam logic [3:0] OP_STORE = 4'd12;
  localparam logic [3:0] OP_TSTZ  = 4'd13;

  // Architectural state
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pending;
  logic              r_ld_req;
  logic [AW-1:0]     r_ld_req_dst;
  logic              r_st_valid;
  logic [DATA_W-1:0] r_st_data;
  logic              r_zero_flag;
  logic              r_err;

  // Decode and datapath wires
  logic              w_reads_src;
  logic              w_writes_dst;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_tstz;
  logic              w_stall;
  logic              w_accept;
  logic              w_ld_hit;
  logic              w_ld_stray;
  logic [DATA_W-1:0] w_src_val;
  logic [DATA_W-1:0] w_dst_val;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_mask;
  logic [KW-1:0]     w_sh;
  logic [KW:0]       w_sh_inv;

  assign w_src_val = r_regs[i_src];
  assign w_dst_val = r_regs[i_dst];
  assign w_sh      = i_imm[KW-1:0];
  assign w_sh_inv  = (KW+1)'(DATA_W) - {1'b0, w_sh};
  assign w_mask    = DATA_W'(1) << w_sh;

  // Classify the opcode by which operands it touches and what it produces
  always_comb begin
    w_reads_src  = 1'b0;
    w_writes_dst = 1'b0;
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_is_tstz    = 1'b0;
    case (i_op)
      OP_MOV, OP_INC, OP_DEC, OP_ADDI, OP_SHLP, OP_SHRP: begin
        w_reads_src  = 1'b1;
        w_writes_dst = 1'b1;
      end
      OP_LIT, OP_SETB, OP_CLRB, OP_FLIPB: begin
        w_writes_dst = 1'b1;
      end
      OP_LOAD: begin
        w_is_load = 1'b1;
      end
      OP_STORE: begin
        w_reads_src = 1'b1;
        w_is_store  = 1'b1;
      end
      OP_TSTZ: begin
        w_reads_src = 1'b1;
        w_is_tstz   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Stall on any read or write of a register whose load is still outstanding;
  // the decision uses registered pending only, so a return does not bypass
  always_comb begin
    w_stall = 1'b0;
    if (i_op_valid) begin
      if (w_reads_src && r_pending[i_src]) begin
        w_stall = 1'b1;
      end
      if ((w_writes_dst || w_is_load) && r_pending[i_dst]) begin
        w_stall = 1'b1;
      end
    end
  end

  assign o_op_ready = ~w_stall;
  assign w_accept   = i_op_valid & ~w_stall;

  // A return to a non-pending register is dropped; register 0 never pends,
  // so its returns are dropped silently rather than flagged
  assign w_ld_hit   = i_ld_valid & r_pending[i_ld_dst];
  assign w_ld_stray = i_ld_valid & ~r_pending[i_ld_dst] & (i_ld_dst != '0);

  // Single-cycle operation unit producing the value written to R[dst]
  always_comb begin
    w_result = w_dst_val;
    case (i_op)
      OP_MOV:   w_result = w_src_val;
      OP_INC:   w_result = w_src_val + DATA_W'(1);
      OP_DEC:   w_result = w_src_val - DATA_W'(1);
      OP_ADDI:  w_result = w_src_val + DATA_W'(i_imm);
      OP_LIT:   w_result = (w_dst_val << IMM_W) | DATA_W'(i_imm);
      OP_SETB:  w_result = w_dst_val | w_mask;
      OP_CLRB:  w_result = w_dst_val & ~w_mask;
      OP_FLIPB: w_result = w_dst_val ^ w_mask;
      OP_SHLP: begin
        if (w_sh == '0) begin
          w_result = w_src_val;
        end else begin
          w_result = (w_dst_val << w_sh) | (w_src_val >> w_sh_inv);
        end
      end
      OP_SHRP: begin
        if (w_sh == '0) begin
          w_result = w_src_val;
        end else begin
          w_result = (w_src_val << w_sh_inv) | (w_dst_val >> w_sh);
        end
      end
      OP_NOP:   w_result = w_dst_val;
      default:  w_result = w_dst_val;
    endcase
  end

  // Register array: load returns and op results commit in the same cycle,
  // always to different registers; register 0 is never written
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_ld_hit && (i_ld_dst == AW'(i))) begin
          r_regs[i] <= i_ld_data;
        end else if (w_accept && w_writes_dst && (i_dst == AW'(i))) begin
          r_regs[i] <= w_result;
        end
      end
    end
  end

  // Scoreboard: set on LOAD accept, cleared by the matching return
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending[0] <= 1'b0;
      for (int i = 1; i < NREGS; i++) begin
        if (w_accept && w_is_load && (i_dst == AW'(i))) begin
          r_pending[i] <= 1'b1;
        end else if (w_ld_hit && (i_ld_dst == AW'(i))) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Registered side outputs: one-cycle pulses for load issue and store
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_req     <= 1'b0;
      r_ld_req_dst <= '0;
      r_st_valid   <= 1'b0;
      r_st_data    <= '0;
      r_zero_flag  <= 1'b0;
    end else begin
      r_ld_req   <= w_accept & w_is_load;
      r_st_valid <= w_accept & w_is_store;
      if (w_accept && w_is_load) begin
        r_ld_req_dst <= i_dst;
      end
      if (w_accept && w_is_store) begin
        r_st_data <= w_src_val;
      end
      if (w_accept && w_is_tstz) begin
        r_zero_flag <= (w_src_val == '0);
      end
    end
  end

  // Sticky error for a stray load return; only reset clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_ld_stray) begin
      r_err <= 1'b1;
    end
  end

  assign o_ld_req     = r_ld_req;
  assign o_ld_req_dst = r_ld_req_dst;
  assign o_st_valid   = r_st_valid;
  assign o_st_data    = r_st_data;
  assign o_zero_flag  = r_zero_flag;
  assign o_err        = r_err;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven directed vectors for the operation unit plus
// hand-written sequences for the load scoreboard, stray returns and reset.
module tb_regfile_sb;

  localparam int DATA_W = 8;
  localparam int NREGS  = 16;
  localparam int AW     = 4;
  localparam int IMM_W  = 4;

  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_INC   = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_LIT   = 4'd5;
  localparam logic [3:0] OP_SETB  = 4'd6;
  localparam logic [3:0] OP_CLRB  = 4'd7;
  localparam logic [3:0] OP_FLIPB = 4'd8;
  localparam logic [3:0] OP_SHLP  = 4'd9;
  localparam logic [3:0] OP_SHRP  = 4'd10;
  localparam logic [3:0] OP_LOAD  = 4'd11;
  localparam logic [3:0] OP_STORE = 4'd12;
  localparam logic [3:0] OP_TSTZ  = 4'd13;

  localparam int CHK_NONE = 0;
  localparam int CHK_ST   = 1;
  localparam int CHK_ZF   = 2;

  logic              clk;
  logic              rst_n;
  logic              op_valid;
  logic [3:0]        op;
  logic [AW-1:0]     src;
  logic [AW-1:0]     dst;
  logic [IMM_W-1:0]  imm;
  logic              op_ready;
  logic              ld_req;
  logic [AW-1:0]     ld_req_dst;
  logic              ld_valid;
  logic [AW-1:0]     ld_dst;
  logic [DATA_W-1:0] ld_data;
  logic              st_valid;
  logic [DATA_W-1:0] st_data;
  logic              zero_flag;
  logic              err;

  regfile_sb #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .AW    (AW),
    .IMM_W (IMM_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_op_valid  (op_valid),
    .i_op        (op),
    .i_src       (src),
    .i_dst       (dst),
    .i_imm       (imm),
    .o_op_ready  (op_ready),
    .o_ld_req    (ld_req),
    .o_ld_req_dst(ld_req_dst),
    .i_ld_valid  (ld_valid),
    .i_ld_dst    (ld_dst),
    .i_ld_data   (ld_data),
    .o_st_valid  (st_valid),
    .o_st_data   (st_data),
    .o_zero_flag (zero_flag),
    .o_err       (err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic [AW-1:0]    src;
    logic [AW-1:0]    dst;
    logic [IMM_W-1:0] imm;
    int               chk;
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  logic readySeen;

  function automatic void addVec(input logic [3:0] o, input logic [AW-1:0] s,
                                 input logic [AW-1:0] d, input logic [IMM_W-1:0] im,
                                 input int c, input logic [7:0] e);
    vec_t v;
    v.op  = o;
    v.src = s;
    v.dst = d;
    v.imm = im;
    v.chk = c;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one op for a single cycle; outputs are sampled 1 time unit after the edge
  task automatic applyStimulus(input logic [3:0] o, input logic [AW-1:0] s,
                               input logic [AW-1:0] d, input logic [IMM_W-1:0] im);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    src      = s;
    dst      = d;
    imm      = im;
    #1;
    readySeen = op_ready;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Operation-unit vectors with hand-computed results
    addVec(OP_STORE, 0, 0, 0, CHK_ST, 8'h00);
    addVec(OP_MOV,   0, 3, 0, CHK_NONE, 8'h00);
    addVec(OP_INC,   3, 3, 0, CHK_NONE, 8'h00);
    addVec(OP_INC,   3, 3, 0, CHK_NONE, 8'h00);
    addVec(OP_STORE, 3, 0, 0, CHK_ST, 8'h02);
    addVec(OP_DEC,   5, 5, 0, CHK_NONE, 8'h00);
    addVec(OP_STORE, 5, 0, 0, CHK_ST, 8'hFF);
    addVec(OP_ADDI,  5, 5, 3, CHK_NONE, 8'h00);
    addVec(OP_STORE, 5, 0, 0, CHK_ST, 8'h02);
    addVec(OP_TSTZ,  5, 0, 0, CHK_ZF, 8'h00);
    addVec(OP_TSTZ,  0, 0, 0, CHK_ZF, 8'h01);
    addVec(OP_LIT,   0, 4, 4'hA, CHK_NONE, 8'h00);
    addVec(OP_LIT,   0, 4, 4'h5, CHK_NONE, 8'h00);
    addVec(OP_STORE, 4, 0, 0, CHK_ST, 8'hA5);
    addVec(OP_FLIPB, 0, 4, 0, CHK_NONE, 8'h00);
    addVec(OP_STORE, 4, 0, 0, CHK_ST, 8'hA4);
    addVec(OP_SETB,  0, 4, 3, CHK_NONE, 8'h00);
    addVec(OP_STORE, 4, 0, 0, CHK_ST, 8'hAC);
    addVec(OP_CLRB,  0, 4, 7, CHK_NONE, 8'h00);
    addVec(OP_STORE, 4, 0, 0, CHK_ST, 8'h2C);
    addVec(OP_SETB,  0, 4, 8, CHK_NONE, 8'h00);
    addVec(OP_STORE, 4, 0, 0, CHK_ST, 8'h2D);
    addVec(OP_LIT,   0, 1, 1, CHK_NONE, 8'h00);
    addVec(OP_LIT,   0, 1, 2, CHK_NONE, 8'h00);
    addVec(OP_LIT,   0, 2, 3, CHK_NONE, 8'h00);
    addVec(OP_LIT,   0, 2, 4, CHK_NONE, 8'h00);
    addVec(OP_STORE, 2, 0, 0, CHK_ST, 8'h34);
    addVec(OP_SHLP,  1, 2, 4, CHK_NONE, 8'h00);
    addVec(OP_STORE, 2, 0, 0, CHK_ST, 8'h41);
    addVec(OP_SHRP,  1, 2, 4, CHK_NONE, 8'h00);
    addVec(OP_STORE, 2, 0, 0, CHK_ST, 8'h24);
    addVec(OP_SHRP,  1, 2, 0, CHK_NONE, 8'h00);
    addVec(OP_STORE, 2, 0, 0, CHK_ST, 8'h12);
    addVec(OP_SHLP,  1, 2, 1, CHK_NONE, 8'h00);
    addVec(OP_STORE, 2, 0, 0, CHK_ST, 8'h24);
    addVec(OP_SHRP,  1, 2, 9, CHK_NONE, 8'h00);
    addVec(OP_STORE, 2, 0, 0, CHK_ST, 8'h12);
    addVec(OP_ADDI,  0, 10, 4'hF, CHK_NONE, 8'h00);
    addVec(OP_STORE, 10, 0, 0, CHK_ST, 8'h0F);
    addVec(OP_DEC,   0, 12, 0, CHK_NONE, 8'h00);
    addVec(OP_INC,   12, 12, 0, CHK_NONE, 8'h00);
    addVec(OP_STORE, 12, 0, 0, CHK_ST, 8'h00);
    addVec(OP_INC,   3, 0, 0, CHK_NONE, 8'h00);
    addVec(OP_STORE, 0, 0, 0, CHK_ST, 8'h00);
    addVec(OP_TSTZ,  12, 0, 0, CHK_ZF, 8'h01);
    addVec(OP_MOV,   4, 13, 0, CHK_NONE, 8'h00);
    addVec(OP_STORE, 13, 0, 0, CHK_ST, 8'h2D);
    addVec(4'd14,    4, 4, 4'hF, CHK_NONE, 8'h00);
    addVec(OP_STORE, 4, 0, 0, CHK_ST, 8'h2D);

    op_valid = 1'b0;
    op       = '0;
    src      = '0;
    dst      = '0;
    imm      = '0;
    ld_valid = 1'b0;
    ld_dst   = '0;
    ld_data  = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset st_valid", st_valid, 0);
    checkOutput("reset st_data", st_data, 0);
    checkOutput("reset zero_flag", zero_flag, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset ld_req", ld_req, 0);
    checkOutput("reset ready", op_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].imm);
      checkOutput($sformatf("vec%0d ready", i), readySeen, 1);
      if (vecs[i].chk == CHK_ST) begin
        checkOutput($sformatf("vec%0d st_valid", i), st_valid, 1);
        checkOutput($sformatf("vec%0d st_data", i), st_data, vecs[i].exp);
      end else if (vecs[i].chk == CHK_ZF) begin
        checkOutput($sformatf("vec%0d zero_flag", i), zero_flag, vecs[i].exp);
      end
    end

    // Store strobe lasts exactly one cycle
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("st_valid pulse width", st_valid, 0);

    // Load r6, then a dependent MOV stalls until after the return cycle
    @(negedge clk);
    op_valid = 1'b1; op = OP_LOAD; src = 0; dst = 6; imm = 0;
    #1;
    checkOutput("load ready", op_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("ld_req issue", ld_req, 1);
    checkOutput("ld_req_dst", ld_req_dst, 6);
    @(negedge clk);
    op = OP_MOV; src = 6; dst = 7;
    #1;
    checkOutput("dep src stall", op_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("ld_req pulse width", ld_req, 0);
    @(negedge clk);
    op = OP_INC; src = 8; dst = 8;
    #1;
    checkOutput("indep op ready", op_ready, 1);
    @(negedge clk);
    op = OP_LIT; src = 0; dst = 6; imm = 4'h3;
    #1;
    checkOutput("dep dst stall", op_ready, 0);
    @(negedge clk);
    op = OP_STORE; src = 6; dst = 0; imm = 0;
    #1;
    checkOutput("dep store stall", op_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("stalled store no pulse", st_valid, 0);
    @(negedge clk);
    op = OP_MOV; src = 6; dst = 7;
    ld_valid = 1'b1; ld_dst = 6; ld_data = 8'h5A;
    #1;
    checkOutput("return cycle still stalled", op_ready, 0);
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    checkOutput("ready after return", op_ready, 1);
    applyStimulus(OP_STORE, 7, 0, 0);
    checkOutput("r7 after load", st_data, 8'h5A);
    applyStimulus(OP_STORE, 6, 0, 0);
    checkOutput("r6 loaded", st_data, 8'h5A);
    applyStimulus(OP_STORE, 8, 0, 0);
    checkOutput("r8 independent inc", st_data, 8'h01);
    checkOutput("no err on good return", err, 0);

    // LOAD to r0 issues a request but never pends; its return is silent
    applyStimulus(OP_LOAD, 0, 0, 0);
    checkOutput("r0 load ld_req", ld_req, 1);
    checkOutput("r0 load ld_req_dst", ld_req_dst, 0);
    applyStimulus(OP_INC, 0, 0, 0);
    checkOutput("r0 not pending", readySeen, 1);
    @(negedge clk);
    op_valid = 1'b0;
    ld_valid = 1'b1; ld_dst = 0; ld_data = 8'h33;
    @(posedge clk);
    #1;
    checkOutput("r0 return no err", err, 0);

    // Stray return to r9 sets sticky err and leaves r9 untouched
    @(negedge clk);
    ld_dst = 9; ld_data = 8'h77;
    @(posedge clk);
    #1;
    checkOutput("stray err set", err, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("err sticky", err, 1);
    applyStimulus(OP_STORE, 9, 0, 0);
    checkOutput("r9 unchanged", st_data, 8'h00);

    // Reset with a load outstanding: async clear, pending dropped, late return flagged
    applyStimulus(OP_LOAD, 0, 6, 0);
    @(negedge clk);
    op_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async err clear", err, 0);
    checkOutput("async zero_flag clear", zero_flag, 0);
    checkOutput("async ld_req_dst clear", ld_req_dst, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_MOV, 6, 7, 0);
    checkOutput("pending dropped by reset", readySeen, 1);
    applyStimulus(OP_STORE, 7, 0, 0);
    checkOutput("r7 cleared by reset", st_data, 8'h00);
    @(negedge clk);
    op_valid = 1'b0;
    ld_valid = 1'b1; ld_dst = 6; ld_data = 8'h99;
    @(posedge clk);
    #1;
    checkOutput("late return err", err, 1);
    @(negedge clk);
    ld_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
